seq_mult_serial_in: RTL and testbench

Sequential unsigned WIDTH x WIDTH multiplier that takes both operands over one shared serial input bus.
- A one-cycle start strobe is followed by operand A on the next cycle and operand B on the cycle after.
- The product is computed by an iterative shift-add datapath.
- Completion is flagged with a one-cycle done pulse; the product stays on out_data until the next operation completes.
- Used as a small arithmetic slave behind a start/done handshake.

---
 rtl/seq_mult_serial_in_if.sv | 31 +++
 rtl/seq_mult_serial_in.sv | 132 +++++++++++++
 tb/tb_seq_mult_serial_in.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seq_mult_serial_in_if.sv
// seq_mult_serial_in_if
//   Start/done handshake and data bus for the serial-input multiplier.
//   master : drives start_i and in_data; observes done_o and out_data.
//   slave  : the multiplier; samples start_i and in_data; drives done_o and out_data.
// Signals:
//   start_i  : start request, one cycle.
//   in_data  : WIDTH-bit shared operand bus (A on the cycle after start, then B).
//   done_o   : one-cycle completion pulse.
//   out_data : 2*WIDTH-bit registered product.
interface seq_mult_serial_in_if #(
  parameter int WIDTH = 4
);
  logic               start_i;
  logic [WIDTH-1:0]   in_data;
  logic               done_o;
  logic [2*WIDTH-1:0] out_data;

  modport master (
    output start_i,
    output in_data,
    input  done_o,
    input  out_data
  );

  modport slave (
    input  start_i,
    input  in_data,
    output done_o,
    output out_data
  );
endinterface

// File: rtl/seq_mult_serial_in.sv
// seq_mult_serial_in
//   Sequential unsigned WIDTH x WIDTH multiplier. A start strobe is followed
//   by operand A and then operand B on the shared in_data bus. The product is
//   built by WIDTH shift-add iterations, published on out_data, and flagged by
//   a one-cycle done_o pulse. out_data holds until the next product is ready.
// Ports:
//   clk_in : clock, all state updates on the rising edge.
//   rst_in : synchronous active-high reset, highest priority.
//   bus    : slave side of seq_mult_serial_in_if (start_i, in_data, done_o,
//            out_data).
module seq_mult_serial_in #(
  parameter int WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  seq_mult_serial_in_if.slave  bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  // Multiplicand is kept 2*WIDTH wide so it can shift left without loss.
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [PW-1:0]    add_term;
  logic [PW-1:0]    acc_sum;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    prod_d   = prod_q;

    // One shift-add step: add the current multiplicand when the multiplier
    // LSB is set. The final step's sum is the complete product.
    add_term = mplier_q[0] ? mcand_q : '0;
    acc_sum  = acc_q + add_term;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = LOAD_A;
        end
      end

      LOAD_A: begin
        mcand_d = {{WIDTH{1'b0}}, bus.in_data};
        state_d = LOAD_B;
      end

      LOAD_B: begin
        mplier_d = bus.in_data;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = CALC;
      end

      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // No early exit on a zero multiplier: latency is always WIDTH steps.
        if (cnt_q == LAST_ITER) begin
          prod_d  = acc_sum;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.done_o   = done_q;
  assign bus.out_data = prod_q;

endmodule

// File: tb/tb_seq_mult_serial_in.sv
// tb_seq_mult_serial_in
//   Self-checking bench for seq_mult_serial_in (WIDTH = 4): reset behaviour,
//   a table of fixed operand pairs, random back-to-back operations checked
//   against plain a*b, start ignored during CALC, and reset mid-operation.
module tb_seq_mult_serial_in;

  localparam int W = 4;

  logic clk;
  logic rst;

  int tests_run;
  int tests_failed;

  seq_mult_serial_in_if #(.WIDTH(W)) bus ();

  seq_mult_serial_in #(.WIDTH(W)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } vec_t;

  vec_t vecs[8];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full operation starting from IDLE (or the DONE->IDLE edge having
  // just passed). Checks latency, product, single-cycle done and hold.
  // pulse_at >= 3 raises start_i for one cycle after that edge count.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2*W-1:0] expected,
                                input int pulse_at);
    int lat;
    lat = 0;
    bus.start_i = 1'b1;
    tick();                       // E0: start sampled
    bus.start_i = 1'b0;
    bus.in_data = a;
    tick();                       // E1: A captured
    bus.in_data = b;
    tick();                       // E2: B captured
    bus.in_data = W'($urandom);
    for (int k = 3; k <= 20; k++) begin
      tick();
      if (k == pulse_at) bus.start_i = 1'b1;
      else bus.start_i = 1'b0;
      if (bus.done_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    bus.start_i = 1'b0;
    if (lat == 0) begin
      check_output("done_timeout", 32'(lat), 32'(W + 2));
    end else begin
      check_output("latency", 32'(lat), 32'(W + 2));
      check_output("product", 32'(bus.out_data), 32'(expected));
      tick();
      check_output("done_width", 32'(bus.done_o), 32'd0);
      check_output("product_hold", 32'(bus.out_data), 32'(expected));
    end
  endtask

  initial begin
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2*W-1:0] model;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  prod: 8'd15};
    vecs[1] = '{a: 4'd15, b: 4'd15, prod: 8'd225};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  prod: 8'd0};
    vecs[3] = '{a: 4'd9,  b: 4'd0,  prod: 8'd0};
    vecs[4] = '{a: 4'd1,  b: 4'd1,  prod: 8'd1};
    vecs[5] = '{a: 4'd15, b: 4'd1,  prod: 8'd15};
    vecs[6] = '{a: 4'd12, b: 4'd11, prod: 8'd132};
    vecs[7] = '{a: 4'd8,  b: 4'd2,  prod: 8'd16};

    // Reset held with start high: nothing may start or pulse.
    rst         = 1'b1;
    bus.start_i = 1'b1;
    bus.in_data = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("reset_done", 32'(bus.done_o), 32'd0);
      check_output("reset_out", 32'(bus.out_data), 32'd0);
    end
    rst         = 1'b0;
    bus.start_i = 1'b0;
    tick();
    check_output("idle_done", 32'(bus.done_o), 32'd0);

    // Fixed vectors.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].prod, -1);
    end

    // Random back-to-back operations against plain multiplication.
    for (int i = 0; i < 20; i++) begin
      ra    = W'($urandom_range(0, (1 << W) - 1));
      rb    = W'($urandom_range(0, (1 << W) - 1));
      model = (2*W)'(int'(ra) * int'(rb));
      apply_stimulus(ra, rb, model, -1);
    end

    // Start pulsed during CALC must be ignored.
    apply_stimulus(4'd7, 4'd6, 8'd42, 4);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("no_extra_done", 32'(bus.done_o), 32'd0);
    end
    check_output("ignored_start_out", 32'(bus.out_data), 32'd42);

    // Reset during CALC of 9*9 aborts with no done pulse.
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.in_data = 4'd9;
    tick();
    bus.in_data = 4'd9;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_output("midrst_out", 32'(bus.out_data), 32'd0);
    check_output("midrst_done", 32'(bus.done_o), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("midrst_no_done", 32'(bus.done_o), 32'd0);
    end
    check_output("midrst_out_hold", 32'(bus.out_data), 32'd0);
    apply_stimulus(4'd2, 4'd8, 8'd16, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
